// File: rtl/l1_cache_ctrl_pkg.sv
// Shared types for the L1 data cache: FSM states, derived widths
// and the per-line storage record.
package l1_cache_pkg;

  localparam int L1_DATA_W     = 32;
  localparam int L1_ADDR_W     = 32;
  localparam int L1_LINES      = 16;
  localparam int L1_WORD_BYTES = 4;
  localparam int L1_CNT_W      = 16;

  localparam int OFFSET_W = $clog2(L1_WORD_BYTES);
  localparam int INDEX_W  = $clog2(L1_LINES);
  localparam int TAG_W    = L1_ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    TAG_CHECK,
    WRITE_BACK,
    ALLOCATE
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_W-1:0]     tag;
    logic [L1_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/l1_cache_ctrl_if.sv
// Word-wide load/store request bus; used both on the CPU side
// (cache is slave) and the L2 side (cache is master).
interface l1_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          read;
  logic          write;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          hit;

  modport master (
    output addr, wdata, read, write,
    input  rdata, ready, hit
  );

  modport slave (
    input  addr, wdata, read, write,
    output rdata, ready, hit
  );
endinterface

// File: rtl/l1_cache_ctrl_line_store.sv
// Direct-mapped line array: one async read port, one write port.
// Reset clears only valid/dirty; tag and data keep their contents.
module l1_line_store
  import l1_cache_pkg::*;
#(
  parameter int NUM_LINES = L1_LINES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
  output line_t                        rd_line,
  input  logic                         we,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
  input  line_t                        wr_line
);

  line_t mem_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].dirty <= 1'b0;
      end
    end else if (we) begin
      mem_q[wr_idx] <= wr_line;
    end
  end

  assign rd_line = mem_q[rd_idx];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Dirty victims are written back to L2 before the refill.
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = L1_DATA_W,
  parameter int ADDR_WIDTH = L1_ADDR_W,
  parameter int NUM_LINES  = L1_LINES,
  parameter int WORD_BYTES = L1_WORD_BYTES,
  parameter int CNT_WIDTH  = L1_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  l1_mem_if.slave              cpu,
  l1_mem_if.master             l2,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int OW  = $clog2(WORD_BYTES);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int WAW = ADDR_WIDTH - OW;
  localparam int TW  = WAW - IW;

  state_e state_q, state_d;

  logic [WAW-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;

  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  cpu_hit_q, cpu_hit_d;
  logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;
  logic                  l2_read_q, l2_read_d;
  logic                  l2_write_q, l2_write_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  line_t         rd_line;
  line_t         wr_line;
  logic          we;
  logic          line_hit;
  logic          unused_ok;

  assign idx      = addr_q[IW-1:0];
  assign tag      = addr_q[WAW-1:IW];
  assign line_hit = rd_line.valid && (rd_line.tag == tag);

  // Offset bits never matter; L2 hit status is reserved.
  assign unused_ok = ^{l2.hit, cpu.addr[OW-1:0]};

  l1_line_store #(
    .NUM_LINES (NUM_LINES)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_line (rd_line),
    .we      (we),
    .wr_idx  (idx),
    .wr_line (wr_line)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    l2_addr_d   = l2_addr_q;
    l2_wdata_d  = l2_wdata_q;
    l2_read_d   = l2_read_q;
    l2_write_d  = l2_write_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    we          = 1'b0;
    wr_line     = rd_line;

    unique case (state_q)
      IDLE: begin
        if (cpu.read || cpu.write) begin
          addr_d  = cpu.addr[ADDR_WIDTH-1:OW];
          wdata_d = cpu.wdata;
          wr_d    = cpu.write;
          state_d = TAG_CHECK;
        end
      end
      TAG_CHECK: begin
        if (line_hit) begin
          if (wr_q) begin
            we            = 1'b1;
            wr_line.data  = wdata_q;
            wr_line.dirty = 1'b1;
          end else begin
            cpu_rdata_d = rd_line.data;
          end
          cpu_ready_d = 1'b1;
          cpu_hit_d   = 1'b1;
          if (~&hit_q) hit_d = hit_q + 1'b1;
          state_d = IDLE;
        end else begin
          if (~&miss_q) miss_d = miss_q + 1'b1;
          if (rd_line.valid && rd_line.dirty) begin
            l2_write_d = 1'b1;
            l2_addr_d  = {rd_line.tag, idx, {OW{1'b0}}};
            l2_wdata_d = rd_line.data;
            state_d    = WRITE_BACK;
          end else begin
            l2_read_d = 1'b1;
            l2_addr_d = {addr_q, {OW{1'b0}}};
            state_d   = ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        if (l2.ready) begin
          l2_write_d    = 1'b0;
          we            = 1'b1;
          wr_line.dirty = 1'b0;
          l2_read_d     = 1'b1;
          l2_addr_d     = {addr_q, {OW{1'b0}}};
          state_d       = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (l2.ready) begin
          l2_read_d     = 1'b0;
          we            = 1'b1;
          wr_line.valid = 1'b1;
          wr_line.tag   = tag;
          wr_line.dirty = wr_q;
          wr_line.data  = wr_q ? wdata_q : l2.rdata;
          if (!wr_q) cpu_rdata_d = l2.rdata;
          cpu_ready_d = 1'b1;
          cpu_hit_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      l2_addr_q   <= '0;
      l2_wdata_q  <= '0;
      l2_read_q   <= 1'b0;
      l2_write_q  <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      l2_addr_q   <= l2_addr_d;
      l2_wdata_q  <= l2_wdata_d;
      l2_read_q   <= l2_read_d;
      l2_write_q  <= l2_write_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign cpu.rdata  = cpu_rdata_q;
  assign cpu.ready  = cpu_ready_q;
  assign cpu.hit    = cpu_hit_q;
  assign l2.addr    = l2_addr_q;
  assign l2.wdata   = l2_wdata_q;
  assign l2.read    = l2_read_q;
  assign l2.write   = l2_write_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Directed bench for l1_cache_ctrl: vector table plus hand sequences
// for back-to-back, counter saturation and reset during refill.
module tb_l1_cache_ctrl;

  localparam int L2_DELAY = 2;

  logic       clk;
  logic       rst;
  logic [3:0] hit_count;
  logic [3:0] miss_count;

  l1_mem_if #(.AW(32), .DW(32)) cpu_if ();
  l1_mem_if #(.AW(32), .DW(32)) l2_if ();

  l1_cache_ctrl #(
    .CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .l2         (l2_if),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } log_t;

  typedef struct {
    string       nm;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] l2d;
    bit          chk_d;
    logic [31:0] exp_d;
    bit          exp_hit;
    int          exp_lat;
    int          exp_hc;
    int          exp_mc;
    int          exp_nl2;
    bit          l2w0;
    logic [31:0] l2a0;
    logic [31:0] l2d0;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          overlap = 0;
  bit          l2_auto = 1'b1;
  int          l2_wait = 0;
  logic [31:0] l2_data = '0;
  logic [31:0] hold_a = '0;
  logic [31:0] hold_d = '0;
  log_t        l2_log [$];
  vec_t        vecs [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // L2 model: answers each request L2_DELAY cycles after it appears.
  initial forever begin
    @(negedge clk);
    if (!l2_auto) begin
      l2_wait = 0;
    end else begin
      l2_if.ready = 1'b0;
      if (l2_if.read || l2_if.write) begin
        if (l2_wait == 0) begin
          hold_a = l2_if.addr;
          hold_d = l2_if.wdata;
        end
        if (l2_wait == L2_DELAY) begin
          log_t e;
          chk("l2_addr_hold", l2_if.addr, hold_a);
          if (l2_if.write) chk("l2_wdata_hold", l2_if.wdata, hold_d);
          e.w = l2_if.write;
          e.a = l2_if.addr;
          e.d = l2_if.wdata;
          l2_log.push_back(e);
          l2_if.rdata = l2_data;
          l2_if.ready = 1'b1;
          l2_wait = 0;
        end else begin
          l2_wait++;
        end
      end else begin
        l2_wait = 0;
      end
    end
  end

  always @(negedge clk)
    if (l2_if.read && l2_if.write) overlap++;

  task automatic cpu_op(input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic hit,
                        output int lat);
    @(negedge clk);
    cpu_if.read  = rd;
    cpu_if.write = wr;
    cpu_if.addr  = addr;
    cpu_if.wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_if.ready && lat < 100);
    chk("cpu_ready", cpu_if.ready, 1);
    rdata = cpu_if.rdata;
    hit   = cpu_if.hit;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rd;
    logic        h;
    int          lat;
    l2_log.delete();
    l2_data = v.l2d;
    cpu_op(v.rd, v.wr, v.addr, v.wdata, rd, h, lat);
    if (v.chk_d) chk({v.nm, "_rdata"}, rd, v.exp_d);
    chk({v.nm, "_hit"}, h, v.exp_hit);
    chk({v.nm, "_lat"}, lat, v.exp_lat);
    chk({v.nm, "_hits"}, hit_count, v.exp_hc);
    chk({v.nm, "_misses"}, miss_count, v.exp_mc);
    chk({v.nm, "_nl2"}, l2_log.size(), v.exp_nl2);
    if (v.exp_nl2 > 0 && l2_log.size() > 0) begin
      chk({v.nm, "_l2w0"}, l2_log[0].w, v.l2w0);
      chk({v.nm, "_l2a0"}, l2_log[0].a, v.l2a0);
      if (v.l2w0) chk({v.nm, "_l2d0"}, l2_log[0].d, v.l2d0);
    end
    if (v.exp_nl2 == 2 && l2_log.size() == 2) begin
      chk({v.nm, "_l2w1"}, l2_log[1].w, 0);
      chk({v.nm, "_l2a1"}, l2_log[1].a, v.addr & 32'hFFFF_FFFC);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_cpu_rdata"}, cpu_if.rdata, 0);
    chk({nm, "_cpu_ready"}, cpu_if.ready, 0);
    chk({nm, "_cpu_hit"}, cpu_if.hit, 0);
    chk({nm, "_l2_addr"}, l2_if.addr, 0);
    chk({nm, "_l2_wdata"}, l2_if.wdata, 0);
    chk({nm, "_l2_read"}, l2_if.read, 0);
    chk({nm, "_l2_write"}, l2_if.write, 0);
    chk({nm, "_hits"}, hit_count, 0);
    chk({nm, "_misses"}, miss_count, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    int          lat;
    int          n;
    bit          seen;
    vec_t        post;

    // name rd wr addr wdata l2d chk_d exp_d hit lat hc mc nl2 w0 a0 d0
    vecs.push_back('{"cold_rd", 1, 0, 32'h100, 0, 32'hDEADBEEF, 1,
                     32'hDEADBEEF, 0, 5, 0, 1, 1, 0, 32'h100, 0});
    vecs.push_back('{"rd_hit", 1, 0, 32'h100, 0, 0, 1,
                     32'hDEADBEEF, 1, 2, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"wr_hit", 0, 1, 32'h100, 32'h12345678, 0, 0,
                     0, 1, 2, 2, 1, 0, 0, 0, 0});
    vecs.push_back('{"rd_after_wr", 1, 0, 32'h100, 0, 0, 1,
                     32'h12345678, 1, 2, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{"dirty_miss", 1, 0, 32'h140, 0, 32'h0BADF00D, 1,
                     32'h0BADF00D, 0, 8, 3, 2, 2, 1, 32'h100,
                     32'h12345678});
    vecs.push_back('{"evicted_rd", 1, 0, 32'h100, 0, 32'h12345678, 1,
                     32'h12345678, 0, 5, 3, 3, 1, 0, 32'h100, 0});
    vecs.push_back('{"wr_miss", 0, 1, 32'h204, 32'hA5A5A5A5, 0, 0,
                     0, 0, 5, 3, 4, 1, 0, 32'h204, 0});
    vecs.push_back('{"wr_alloc_rd", 1, 0, 32'h204, 0, 0, 1,
                     32'hA5A5A5A5, 1, 2, 4, 4, 0, 0, 0, 0});
    vecs.push_back('{"wr_alloc_evict", 1, 0, 32'h244, 0, 32'h44444444, 1,
                     32'h44444444, 0, 8, 4, 5, 2, 1, 32'h204,
                     32'hA5A5A5A5});
    vecs.push_back('{"rd_and_wr", 1, 1, 32'h100, 32'h77, 0, 0,
                     0, 1, 2, 5, 5, 0, 0, 0, 0});
    vecs.push_back('{"rd_after_both", 1, 0, 32'h100, 0, 0, 1,
                     32'h77, 1, 2, 6, 5, 0, 0, 0, 0});
    vecs.push_back('{"offset_ignored", 1, 0, 32'h103, 0, 0, 1,
                     32'h77, 1, 2, 7, 5, 0, 0, 0, 0});

    rst = 1'b1;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
    cpu_if.addr  = '0;
    cpu_if.wdata = '0;
    l2_if.rdata  = '0;
    l2_if.ready  = 1'b0;
    l2_if.hit    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Request held through the ready cycle is taken again.
    @(negedge clk);
    cpu_if.read = 1'b1;
    cpu_if.addr = 32'h100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_if.ready && n < 20);
    chk("b2b_first", cpu_if.ready, 1);
    @(negedge clk);
    chk("b2b_gap", cpu_if.ready, 0);
    @(negedge clk);
    chk("b2b_second", cpu_if.ready, 1);
    chk("b2b_hit", cpu_if.hit, 1);
    cpu_if.read = 1'b0;
    chk("b2b_hits", hit_count, 9);

    for (int i = 0; i < 8; i++) cpu_op(1, 0, 32'h100, 0, rd, h, lat);
    chk("sat_hits", hit_count, 15);
    chk("sat_misses", miss_count, 5);

    // Reset while a refill is outstanding, then a late l2_ready.
    l2_auto = 1'b0;
    @(negedge clk);
    cpu_if.read = 1'b1;
    cpu_if.addr = 32'h308;
    n = 0;
    while (!l2_if.read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_l2_read_seen", l2_if.read, 1);
    chk("rst_l2_addr", l2_if.addr, 32'h308);
    cpu_if.read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_alloc");
    l2_if.rdata = 32'hCAFEF00D;
    l2_if.ready = 1'b1;
    @(negedge clk);
    l2_if.ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_if.ready) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_ready", seen, 0);
    chk("rst_no_l2_read", l2_if.read, 0);
    l2_auto = 1'b1;

    post = '{"post_rst_rd", 1, 0, 32'h100, 0, 32'h11112222, 1,
             32'h11112222, 0, 5, 0, 1, 1, 0, 32'h100, 0};
    run_vec(post);

    chk("l2_exclusive", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
